// File: rtl/frame_dispatch_pkg.sv
// frame_dispatch_pkg: shared types for the frame dispatch scheduler.
// Holds the FSM state encoding, the 140-bit record field layout and a
// packed view of the record as it arrives from the frame FIFO.
package frame_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

  localparam int REC_W   = 140;
  localparam int LEN_MSB = 139;
  localparam int LEN_LSB = 136;
  localparam int CH_MSB  = 135;
  localparam int CH_LSB  = 128;
  localparam int PAY_MSB = 127;

  localparam int LEN_W = LEN_MSB - LEN_LSB + 1;
  localparam int CH_W  = CH_MSB - CH_LSB + 1;
  localparam int PAY_W = PAY_MSB + 1;

  // Word 0 of the payload sits in the top 16 bits of the payload field.
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [CH_W-1:0]  sel;
    logic [PAY_W-1:0] payload;
  } rec_t;

endpackage

// File: rtl/frame_dispatch_sched_watchdog.sv
// dispatch_watchdog: stall counter for the SEND state of the dispatcher.
// Only built when DISPATCH_TIMEOUT_EN is defined. The counter restarts
// whenever the dispatcher is outside SEND or a word is transferred, and
// o_abort is raised on the TIMEOUT-th consecutive stalled SEND cycle.
`ifdef DISPATCH_TIMEOUT_EN
module dispatch_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_in,
  input  logic rst,
  input  logic i_send,
  input  logic i_xfer,
  output logic o_abort
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_stall;

  assign w_stall = i_send && !i_xfer;
  assign o_abort = w_stall && (r_cnt == CNT_W'(TIMEOUT - 1));

  // Count consecutive stalled SEND cycles; restart on transfer, abort or leaving SEND.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!w_stall || o_abort) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/frame_dispatch_sched.sv
// frame_dispatch_sched: pops frame records from the frame FIFO, validates
// them and serializes the payload words onto a shared bus, strobing every
// selected channel. A word only advances when all selected channels are
// ready in the same cycle.
// Optional feature: define DISPATCH_TIMEOUT_EN to build the stall watchdog
// (dispatch_watchdog); otherwise SEND waits forever and timeout_err is 0.
module frame_dispatch_sched
  import frame_dispatch_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_r_enable,
  input  logic [REC_W-1:0]  fifo_r_data,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic [DATA_W-1:0] dout,
  output logic [NUM_CH-1:0] dout_valid,
  output logic              frame_last,
  output logic              frame_err,
  output logic              timeout_err,
  output logic              busy
);

  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  // Word idx of a payload, word 0 in the most significant slot.
  function automatic logic [DATA_W-1:0] word_at(input logic [PAY_W-1:0] pay,
                                                input logic [IDX_W-1:0] idx);
    logic [PAY_W-1:0] sh;
    sh = pay << (DATA_W * int'(idx));
    return sh[PAY_MSB -: DATA_W];
  endfunction

  state_t            r_state;
  state_t            w_next;
  rec_t              w_rec;
  logic              w_illegal;
  logic              w_in_send;
  logic              w_xfer;
  logic              w_last;
  logic              w_abort;
  logic [LEN_W-1:0]  w_len_m1;
  logic [IDX_W-1:0]  w_idx_nxt;

  logic [LEN_W-1:0]  r_len;
  logic [NUM_CH-1:0] r_sel;
  logic [PAY_W-1:0]  r_payload;
  logic [IDX_W-1:0]  r_idx;

  logic [DATA_W-1:0] r_dout;
  logic [NUM_CH-1:0] r_dout_valid;
  logic              r_frame_last;
  logic              r_frame_err;
  logic              r_timeout_err;

  assign w_rec     = rec_t'(fifo_r_data);
  assign w_illegal = (w_rec.len == '0) || (w_rec.len > MAX_LEN) || (w_rec.sel == '0);
  assign w_in_send = (r_state == ST_SEND);
  assign w_xfer    = w_in_send && ((ch_ready & r_sel) == r_sel);
  assign w_len_m1  = r_len - LEN_W'(1);
  assign w_last    = (LEN_W'(r_idx) == w_len_m1);
  assign w_idx_nxt = r_idx + 1'b1;

`ifdef DISPATCH_TIMEOUT_EN
  dispatch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_in  (clk_in),
    .rst     (rst),
    .i_send  (w_in_send),
    .i_xfer  (w_xfer),
    .o_abort (w_abort)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; fifo_empty only matters in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (!fifo_empty) w_next = ST_FETCH;
      ST_FETCH: w_next = ST_LATCH;
      ST_LATCH: w_next = w_illegal ? ST_IDLE : ST_SEND;
      ST_SEND:  if (w_abort || (w_xfer && w_last)) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs: the pop strobe is exactly the FETCH cycle.
  always_comb begin
    fifo_r_enable = (r_state == ST_FETCH);
    busy          = (r_state != ST_IDLE);
  end

  // Record capture in LATCH; contents are only consulted while in SEND.
  always_ff @(posedge clk_in) begin
    if (r_state == ST_LATCH) begin
      r_len     <= w_rec.len;
      r_sel     <= w_rec.sel;
      r_payload <= w_rec.payload;
    end
  end

  // Registered outputs and word index; word 0 is presented straight out of LATCH.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_idx         <= '0;
      r_dout        <= '0;
      r_dout_valid  <= '0;
      r_frame_last  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_frame_err   <= (r_state == ST_LATCH) && w_illegal;
      r_timeout_err <= w_abort;
      case (r_state)
        ST_LATCH: begin
          if (!w_illegal) begin
            r_idx        <= '0;
            r_dout       <= w_rec.payload[PAY_MSB -: DATA_W];
            r_dout_valid <= w_rec.sel;
            r_frame_last <= (w_rec.len == LEN_W'(1));
          end
        end
        ST_SEND: begin
          if (w_abort) begin
            r_dout_valid <= '0;
            r_frame_last <= 1'b0;
          end else if (w_xfer) begin
            if (w_last) begin
              r_dout_valid <= '0;
              r_frame_last <= 1'b0;
            end else begin
              r_idx        <= w_idx_nxt;
              r_dout       <= word_at(r_payload, w_idx_nxt);
              r_frame_last <= (LEN_W'(w_idx_nxt) == w_len_m1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign frame_last  = r_frame_last;
  assign frame_err   = r_frame_err;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_frame_dispatch_sched.sv
// Testbench for frame_dispatch_sched: a queue-based FIFO model feeds records,
// directed tests push expected beats/events into a scoreboard, and a monitor
// compares them against every DUT transfer, frame_err and timeout_err.
module tb_frame_dispatch_sched;

  localparam int K_BEAT = 0;
  localparam int K_FERR = 1;
  localparam int K_TOUT = 2;

  typedef struct {
    int          kind;
    logic [15:0] data;
    logic [7:0]  sel;
    logic        last;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         fifo_empty;
  logic         fifo_r_enable;
  logic [139:0] fifo_r_data;
  logic [7:0]   ch_ready;
  logic [15:0]  dout;
  logic [7:0]   dout_valid;
  logic         frame_last;
  logic         frame_err;
  logic         timeout_err;
  logic         busy;

  logic [139:0] fq[$];
  exp_t         exp_q[$];
  int           beat_cycs[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_pops   = 0;
  int           cyc      = 0;

  frame_dispatch_sched #(
    .NUM_CH    (8),
    .DATA_W    (16),
    .MAX_WORDS (8),
    .TIMEOUT   (10)
  ) dut (
    .clk_in        (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_r_enable (fifo_r_enable),
    .fifo_r_data   (fifo_r_data),
    .ch_ready      (ch_ready),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .frame_last    (frame_last),
    .frame_err     (frame_err),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data appears on fifo_r_data the cycle after the pop.
  always @(posedge clk) begin
    if (fifo_r_enable) begin
      if (fq.size() > 0) fifo_r_data <= fq.pop_front();
      n_pops++;
      fifo_empty = (fq.size() == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic push_rec(input logic [3:0] len, input logic [7:0] sel, input logic [127:0] pay);
    fq.push_back({len, sel, pay});
    fifo_empty = 1'b0;
  endtask

  task automatic exp_beat(input logic [15:0] d, input logic [7:0] s, input logic l);
    exp_t e;
    e.kind = K_BEAT; e.data = d; e.sel = s; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic exp_event(input int k);
    exp_t e;
    e.kind = k; e.data = '0; e.sel = '0; e.last = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic pop_expect(input string name, input int k, output exp_t e, output bit ok);
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: unexpected event, scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k) begin
        n_checks++;
        $display("FAIL %s: event kind %0d, required kind %0d", name, k, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Monitor: sample just before the rising edge, when the inputs the DUT will see are settled.
  always begin
    exp_t e;
    bit   ok;
    @(negedge clk);
    #4;
    if (!rst) begin
      if (frame_err) begin
        pop_expect("frame_err", K_FERR, e, ok);
        if (ok) check("frame_err_pulse", 32'(frame_err), 32'(1));
      end
      if (timeout_err) begin
        pop_expect("timeout_err", K_TOUT, e, ok);
        if (ok) check("timeout_err_pulse", 32'(timeout_err), 32'(1));
      end
      if (dout_valid != 8'h00 && (ch_ready & dout_valid) == dout_valid) begin
        pop_expect("beat", K_BEAT, e, ok);
        if (ok) check("beat", {7'd0, dout, dout_valid, frame_last}, {7'd0, e.data, e.sel, e.last});
        beat_cycs.push_back(cyc);
      end
    end
  end

  task automatic wait_drain(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check(name, 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  task automatic wait_valid(output int n, input int max_cyc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dout_valid == 8'h00 && n < max_cyc);
  endtask

  initial begin
    int n;
    int p0;
    rst         = 1'b1;
    fifo_empty  = 1'b1;
    fifo_r_data = '0;
    ch_ready    = 8'hFF;

    // Reset state
    @(negedge clk);
    check("rst_dout",          32'(dout),          32'(0));
    check("rst_dout_valid",    32'(dout_valid),    32'(0));
    check("rst_frame_last",    32'(frame_last),    32'(0));
    check("rst_frame_err",     32'(frame_err),     32'(0));
    check("rst_timeout_err",   32'(timeout_err),   32'(0));
    check("rst_busy",          32'(busy),          32'(0));
    check("rst_fifo_r_enable", 32'(fifo_r_enable), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single frame, len=3, channel 2
    p0 = n_pops;
    exp_beat(16'hA1A1, 8'h04, 1'b0);
    exp_beat(16'hB2B2, 8'h04, 1'b0);
    exp_beat(16'hC3C3, 8'h04, 1'b1);
    push_rec(4'd3, 8'h04, 128'hA1A1_B2B2_C3C3_0000_0000_0000_0000_0000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fifo_r_enable && n < 20);
    check("pop_latency", 32'(n), 32'(1));
    wait_valid(n, 20);
    check("first_valid_latency", 32'(n), 32'(2));
    wait_drain("single_drain", 20);
    check("single_busy_after",  32'(busy),         32'(0));
    check("single_valid_after", 32'(dout_valid),   32'(0));
    check("single_pops",        32'(n_pops - p0),  32'(1));

    // Broadcast to channels 0 and 7 with channel 7 stalled for 4 cycles
    ch_ready = 8'h7F;
    exp_beat(16'h1111, 8'h81, 1'b0);
    exp_beat(16'h2222, 8'h81, 1'b1);
    push_rec(4'd2, 8'h81, 128'h1111_2222_0000_0000_0000_0000_0000_0000);
    wait_valid(n, 20);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_hold", {8'd0, dout, dout_valid}, {8'd0, 16'h1111, 8'h81});
      ch_ready = (i % 2 == 0) ? 8'h01 : 8'h7F;
    end
    ch_ready = 8'hFF;
    wait_drain("bp_drain", 20);

    // Illegal records: len=0, len=9, sel=0
    p0 = n_pops;
    exp_event(K_FERR);
    exp_event(K_FERR);
    exp_event(K_FERR);
    push_rec(4'd0, 8'h01, 128'hDEAD_0000_0000_0000_0000_0000_0000_0000);
    push_rec(4'd9, 8'h01, 128'hDEAD_0000_0000_0000_0000_0000_0000_0000);
    push_rec(4'd2, 8'h00, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0000);
    wait_drain("illegal_drain", 40);
    repeat (2) @(negedge clk);
    check("illegal_pops", 32'(n_pops - p0), 32'(3));

    // Back-to-back single-word records
    beat_cycs.delete();
    exp_beat(16'h5555, 8'h02, 1'b1);
    exp_beat(16'h6666, 8'h10, 1'b1);
    push_rec(4'd1, 8'h02, 128'h5555_0000_0000_0000_0000_0000_0000_0000);
    push_rec(4'd1, 8'h10, 128'h6666_0000_0000_0000_0000_0000_0000_0000);
    wait_drain("b2b_drain", 30);
    if (beat_cycs.size() == 2) check("b2b_gap", 32'(beat_cycs[1] - beat_cycs[0]), 32'(4));
    else check("b2b_beats", 32'(beat_cycs.size()), 32'(2));

    // Reset during word 2 of a len=5 frame, then the next queued record
    p0 = n_pops;
    exp_beat(16'h0A01, 8'h08, 1'b0);
    exp_beat(16'h0A02, 8'h08, 1'b0);
    push_rec(4'd5, 8'h08, 128'h0A01_0A02_0A03_0A04_0A05_0000_0000_0000);
    push_rec(4'd2, 8'h20, 128'h0B01_0B02_0000_0000_0000_0000_0000_0000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dout_valid != 8'h00 && dout == 16'h0A03) && n < 20);
    rst = 1'b1;
    #1;
    check("mid_rst_dout",       32'(dout),          32'(0));
    check("mid_rst_dout_valid", 32'(dout_valid),    32'(0));
    check("mid_rst_frame_last", 32'(frame_last),    32'(0));
    check("mid_rst_busy",       32'(busy),          32'(0));
    check("mid_rst_words_seen", 32'(exp_q.size()),  32'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    exp_beat(16'h0B01, 8'h20, 1'b0);
    exp_beat(16'h0B02, 8'h20, 1'b1);
    rst = 1'b0;
    wait_drain("after_rst_drain", 30);
    check("after_rst_pops", 32'(n_pops - p0), 32'(2));

`ifdef DISPATCH_TIMEOUT_EN
    // Watchdog abort with TIMEOUT=10
    ch_ready = 8'hFB;
    exp_event(K_TOUT);
    push_rec(4'd2, 8'h04, 128'h7777_8888_0000_0000_0000_0000_0000_0000);
    wait_valid(n, 20);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout_err && n < 30);
    check("timeout_stall_cycles", 32'(n),          32'(10));
    check("timeout_valid_drop",   32'(dout_valid), 32'(0));
    check("timeout_busy",         32'(busy),       32'(0));
    wait_drain("timeout_drain", 10);
    ch_ready = 8'hFF;
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_dispatch_sched.md
# frame_dispatch_sched

Frame dispatch scheduler between the frame FIFO and the per-channel output lanes. Pops one 140-bit frame record at a time from the FIFO filled by the frame parser. It validates the record, then serializes its 16-bit payload words onto a shared output bus. Every channel selected by the record's one-hot channel field receives the words, each paced by a per-channel ready.

## Interface
Parameters:
- NUM_CH, 8, number of output channels (width of channel field, ch_ready, dout_valid)
- DATA_W, 16, payload word width
- MAX_WORDS, 8, maximum payload words per record
- TIMEOUT, 255, stall limit in cycles (used only with watchdog compiled in)

Ports:
- clk_in  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- fifo_empty  input  1  frame FIFO empty flag
- fifo_r_enable  output  1  FIFO pop; read data valid the cycle after
- fifo_r_data  input  140  record: [139:136] word count, [135:128] one-hot channel, [127:0] payload, word 0 at [127:112]
- ch_ready  input  NUM_CH  per-channel ready
- dout  output  DATA_W  current payload word
- dout_valid  output  NUM_CH  one-hot/multi-hot channel strobe
- frame_last  output  1  high with the last word of a frame
- frame_err  output  1  one-cycle pulse on illegal record
- timeout_err  output  1  one-cycle pulse on watchdog abort
- busy  output  1  high whenever state != IDLE

## Operation
- States: IDLE, FETCH, LATCH, SEND.
- IDLE: if !fifo_empty -> FETCH; else stay.
- FETCH: fifo_r_enable=1 for exactly this cycle (decoded from state); -> LATCH.
- LATCH: capture len, sel, payload from fifo_r_data.
  - Illegal record: len==0, len>MAX_WORDS, or sel==0. Register frame_err=1 for the next cycle and -> IDLE; the record is discarded.
  - Otherwise -> SEND with idx=0.
- SEND: dout=payload word idx, dout_valid=sel, frame_last=(idx==len-1).
- Transfer condition: (ch_ready & sel)==sel. All selected channels must be ready in the same cycle; there are no partial transfers.
- On a transfer: if idx==len-1 -> IDLE, else idx+1.
- Without a transfer: dout, dout_valid and frame_last hold stable.
- idx width is clog2(MAX_WORDS). Word select: payload[127-16*idx -: 16].
- Outputs dout, dout_valid, frame_last, frame_err and timeout_err are registered.

## Timing
- Reset value of every output: 0. busy=0 and state=IDLE.
- Reset mid-frame: outputs clear asynchronously; the in-flight record is lost and not re-read.
- Latency: fifo_empty falls at cycle N in IDLE -> fifo_r_enable at N+1 -> first dout_valid at N+3.
- Per-frame overhead: 3 cycles (IDLE, FETCH, LATCH) plus len transfer cycles, given full ready.
- fifo_empty is sampled only in IDLE. No pop is issued while a frame is in SEND.
- fifo_empty rising during FETCH: the FIFO guarantees data was present at the pop, so it is ignored.
- ch_ready toggling on unselected channels has no effect.
- frame_err and timeout_err never both fire in the same cycle.

## Configuration
- DISPATCH_TIMEOUT_EN defined: watchdog active.
  - A stall counter clears on SEND entry and on every transfer, and increments on each SEND cycle without a transfer.
  - When it reaches TIMEOUT, the frame is aborted: dout_valid drops on the next cycle, timeout_err pulses once, and the state goes to IDLE.
- DISPATCH_TIMEOUT_EN undefined: no counter; SEND waits indefinitely; timeout_err tied 0 (port retained).

## Structure
- Package frame_dispatch_pkg holds:
  - the state enum;
  - record field localparams (REC_W=140, LEN_MSB/LSB, CH_MSB/LSB, PAY_MSB);
  - a packed struct for the record.
- Sub-module: dispatch_watchdog (stall counter plus abort pulse), instantiated only under DISPATCH_TIMEOUT_EN.

## Test plan
- Single frame: record len=3, sel=8'h04, payload words A1A1,B2B2,C3C3; ch_ready=all 1s.
  - Required: fifo_r_enable pulse, then three consecutive words on dout with dout_valid=8'h04.
  - frame_last high only with C3C3; busy low afterwards.
- Broadcast with backpressure: sel=8'h81, ch_ready[7]=0 for 4 cycles.
  - Required: word 0 held stable for 4 cycles, advancing only once both bit 0 and bit 7 are ready.
- Illegal records: len=0, then len=9, then sel=0.
  - Required: three frame_err pulses, no dout_valid, and three FIFO pops.
- Back-to-back: two queued records, len=1 each.
  - Required: exactly 3 idle-overhead cycles between the two dout_valid cycles.
- Reset mid-frame: assert rst during word 2 of len=5.
  - Required: all outputs 0 immediately; after release, the next queued record is processed from word 0.
- With DISPATCH_TIMEOUT_EN, TIMEOUT=10: hold the selected ch_ready low.
  - Required: timeout_err pulse after 10 stalled cycles, then return to IDLE.
